// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// One restoring shift-subtract step per cycle; the result leaves as a one-cycle register-file write.
module div_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [XLEN-1:0]    rs1_val,
    input  logic [XLEN-1:0]    rs2_val,
    input  logic [RADDR_W-1:0] rd,
    input  logic               kill,
    output logic               busy,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [XLEN-1:0]    wb_wdata
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               rem_op_q;
    logic [RADDR_W-1:0] rd_q;
    logic [XLEN-1:0]    dvd_q;      // dividend magnitude, quotient bits shift in at the LSB
    logic [XLEN-1:0]    dvs_q;
    logic [XLEN-1:0]    rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_quo_q;
    logic               neg_rem_q;

    // Start decode: operand magnitudes and the cases that bypass the iteration.
    logic            signed_op;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic [XLEN-1:0] special_res;

    always_comb begin
        signed_op   = ~op[0];
        a_neg       = signed_op & rs1_val[XLEN-1];
        b_neg       = signed_op & rs2_val[XLEN-1];
        a_mag       = a_neg ? -rs1_val : rs1_val;
        b_mag       = b_neg ? -rs2_val : rs2_val;
        div_zero    = (rs2_val == '0);
        overflow    = signed_op && (rs1_val == MIN_NEG) && (rs2_val == '1);
        special_res = '0;
        if (op[1]) begin
            special_res = div_zero ? rs1_val : '0;
        end else begin
            special_res = div_zero ? '1 : MIN_NEG;
        end
    end

    // One restoring step: the partial remainder is below the divisor, so the shifted value needs one extra bit.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic            qbit;
    logic [XLEN-1:0] rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_final;
    logic [XLEN-1:0] rem_final;
    logic [XLEN-1:0] result;

    always_comb begin
        shifted   = {rem_q, dvd_q[XLEN-1]};
        trial     = shifted - {1'b0, dvs_q};
        qbit      = ~trial[XLEN];
        rem_next  = qbit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        quo_next  = {dvd_q[XLEN-2:0], qbit};
        quo_final = neg_quo_q ? -quo_next : quo_next;
        rem_final = neg_rem_q ? -rem_next : rem_next;
        result    = rem_op_q ? rem_final : quo_final;
    end

    // Handshake: a request is taken on a rising edge with start=1, kill=0 and busy=0; busy then
    // stays high until the edge after the writeback cycle. wb_we is the only qualifier of wb_waddr/wb_wdata.
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rem_op_q  <= 1'b0;
            rd_q      <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            wb_we     <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_we <= 1'b0;
                    if (start && !kill) begin
                        rem_op_q <= op[1];
                        rd_q     <= rd;
                        if (div_zero || overflow) begin
                            state    <= DONE;
                            wb_we    <= (rd != '0);
                            wb_waddr <= rd;
                            wb_wdata <= special_res;
                        end else begin
                            state     <= CALC;
                            dvd_q     <= a_mag;
                            dvs_q     <= b_mag;
                            rem_q     <= '0;
                            cnt_q     <= '0;
                            neg_quo_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        dvd_q <= quo_next;
                        rem_q <= rem_next;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            state    <= DONE;
                            wb_we    <= (rd_q != '0);
                            wb_waddr <= rd_q;
                            wb_wdata <= result;
                        end
                    end
                end
                DONE: begin
                    // kill here changes nothing: the pulse is already out and the unit frees anyway.
                    wb_we <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wb_we <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, handshake/kill/reset cases and a random sweep,
// with a writeback monitor popping expected {rd, data} entries from a scoreboard queue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        kill;
    logic        busy;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    div_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rd(rd), .kill(kill), .busy(busy), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    // ---- clock ----
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [36:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    logic [31:0] corners[5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            OP_DIV:  return sa / sb;
            OP_DIVU: return a / b;
            OP_REM:  return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'h0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick();
        int s;
        s = $urandom_range(0, 9);
        if (s < 5) return corners[s];
        return $urandom();
    endfunction

    // ---- scoreboard monitor ----
    always @(negedge clk) begin
        if (!rst && wb_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb waddr=%0d wdata=%h", wb_waddr, wb_wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wb_result", {27'h0, wb_waddr, wb_wdata}, {27'h0, e});
            end
        end
    end

    // ---- driver tasks ----
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp);
        int n;
        int we_n;
        logic sp;
        sp = is_special(o, a, b);
        wait_idle();
        @(negedge clk);
        op = o; rs1_val = a; rs2_val = b; rd = r; start = 1'b1;
        if (r != 5'd0) exp_q.push_back({r, exp});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        we_n = wb_we ? 0 : -1;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_we && we_n < 0) we_n = n;
        end
        check("latency", n, sp ? 1 : 33);
        check("wb_timing", we_n, (r == 5'd0) ? -1 : (sp ? 0 : 32));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset ----
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1_val = '0; rs2_val = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_wb_we", wb_we, 0);
        check("reset_waddr", wb_waddr, 0);
        check("reset_wdata", wb_wdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // ---- directed vectors (hand-computed) ----
        vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14});
        vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF});
        vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD});
        vecs.push_back('{OP_DIVU, 32'd1234,       32'd0,          5'd7,  32'hFFFF_FFFF});
        vecs.push_back('{OP_REMU, 32'd1234,       32'd0,          5'd8,  32'd1234});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'h0});
        vecs.push_back('{OP_REMU, 32'd100,        32'd7,          5'd11, 32'd2});
        vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd12, 32'hFFFF_FFFD});
        vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd13, 32'd1});
        vecs.push_back('{OP_DIV,  32'd0,          32'd5,          5'd14, 32'd0});
        vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd15, 32'hFFFF_FFFF});
        vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd1,          5'd16, 32'h8000_0000});
        vecs.push_back('{OP_REM,  32'h8000_0000,  32'd2,          5'd17, 32'h0});
        vecs.push_back('{OP_DIV,  32'd0,          32'd0,          5'd18, 32'hFFFF_FFFF});
        vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd19, 32'hFFFF_FFFB});
        vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'h0000_0003,  5'd31, 32'h2AAA_AAAA});
        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

        // ---- start while busy is ignored ----
        wait_idle();
        @(negedge clk);
        op = OP_DIVU; rs1_val = 32'd50; rs2_val = 32'd5; rd = 5'd1; start = 1'b1;
        exp_q.push_back({5'd1, 32'd10});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = OP_DIVU; rs1_val = 32'd99; rs2_val = 32'd3; rd = 5'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
        repeat (40) @(posedge clk);
        check("ignored_start_drained", exp_q.size(), 0);

        // ---- kill mid-CALC ----
        @(negedge clk);
        op = OP_DIVU; rs1_val = 32'd77; rs2_val = 32'd7; rd = 5'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("busy_after_kill", busy, 0);
        repeat (40) @(posedge clk);
        run_op(OP_DIVU, 32'd81, 32'd9, 5'd4, 32'd9);

        // ---- kill blocks start in IDLE ----
        @(negedge clk);
        op = OP_DIVU; rs1_val = 32'd8; rs2_val = 32'd2; rd = 5'd6; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("kill_blocks_start", busy, 0);

        // ---- asynchronous reset mid-CALC ----
        @(negedge clk);
        op = OP_DIV; rs1_val = 32'd1000; rs2_val = 32'd3; rd = 5'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_wb_we", wb_we, 0);
        check("async_rst_wdata", wb_wdata, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);

        // ---- rd==0: full latency, no write ----
        run_op(OP_DIVU, 32'd9, 32'd3, 5'd0, 32'd3);

        // ---- random sweep against the reference model ----
        for (int k = 0; k < 1000; k++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  r;
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            r = 5'($urandom_range(0, 31));
            run_op(o, a, b, r, ref_model(o, a, b));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit: DIV, DIVU, REM, REMU.
- Sits in the execute stage. Its result drives the write port of the 32-entry register file (we/waddr/wdata), alongside the ALU writeback path.
- Accepts one operation at a time through a start/busy handshake.
- Produces a one-cycle writeback pulse when the result is ready.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- RADDR_W, 5, destination register address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- op  input  2  operation: 00=DIV, 01=DIVU, 10=REM, 11=REMU.
- rs1_val  input  XLEN  dividend.
- rs2_val  input  XLEN  divisor.
- rd  input  RADDR_W  destination register.
- kill  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  high while an operation is in flight (CALC or DONE).
- wb_we  output  1  register-file write enable, one-cycle pulse.
- wb_waddr  output  RADDR_W  register-file write address.
- wb_wdata  output  XLEN  register-file write data.

Behaviour:
- Clocking/reset: one clock domain (clk). rst is asynchronous and active-high. While rst=1: state=IDLE, busy=0, wb_we=0, wb_waddr=0, wb_wdata=0, counter and datapath registers cleared. rst mid-operation discards the operation with no writeback.
- States: IDLE, CALC, DONE.
- IDLE: on an edge with start=1, the unit captures op, rd and the operands.
  - Divisor==0 or signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): go directly to DONE with the special result.
  - Otherwise: go to CALC with counter=0.
- CALC: restoring shift-subtract on magnitudes, one quotient bit per cycle, MSB first.
  - Signed ops use |rs1| and |rs2|, captured at the start edge.
  - counter increments each edge. On the edge where counter==31, the final bit is resolved, sign correction is applied, the result is registered and the state moves to DONE.
- DONE: wb_we=1 for exactly this cycle (unless rd==0), with wb_waddr=rd and wb_wdata=result. The next edge returns to IDLE.
- busy is combinationally (state!=IDLE). start is ignored while busy=1; there is no queueing.
- Latency: start sampled at edge N.
  - Normal operation: wb_we is high in the cycle after edge N+32 (DONE entered at N+32, IDLE at N+33). A new start is accepted at edge N+33 at the earliest.
  - Special cases: wb_we is high in the cycle after edge N.
- Results:
  - DIV: quotient truncated toward zero; negative if operand signs differ and the quotient is nonzero.
  - REM: remainder takes the sign of the dividend.
  - DIVU/REMU: unsigned.
  - Divisor zero: quotient=0xFFFFFFFF, remainder=rs1_val.
  - Overflow: quotient=0x80000000, remainder=0.
- rd==0: the computation runs normally, busy timing is unchanged, wb_we stays 0.
- kill: on any edge with kill=1 in CALC or DONE, the state goes to IDLE with no writeback. If kill=1 in DONE, wb_we is still visible during that cycle; the consumer gates it. kill has priority over start in IDLE: start with kill=1 is not accepted.
- wb_waddr/wb_wdata hold their last values outside DONE; only wb_we qualifies them.

Test Plan:
- DIVU 100/7, rd=5, start at edge N -> busy=1 from N; wb_we=1, wb_waddr=5, wb_wdata=14 in the cycle after edge N+32; IDLE after N+33.
- REM rs1=0xFFFFFFF9 (-7), rs2=2, rd=3 -> wb_wdata=0xFFFFFFFF (-1); DIV of the same operands -> 0xFFFFFFFD (-3).
- DIVU 1234/0 -> wb_wdata=0xFFFFFFFF in the cycle after edge N; REMU 1234/0 -> 1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Start DIVU 50/5; pulse start with different operands at N+10 -> second request ignored, single writeback of 10; kill at N+20 on a new op -> no wb_we pulse, busy=0 after the kill edge, next start accepted.
- Assert rst at N+15 mid-CALC -> busy=0 and wb_we=0 immediately (asynchronous), no writeback ever appears. DIVU 9/3 with rd=0 -> full latency, wb_we never asserted.
- Random 1000 ops, all four opcodes including corner operands (0, 1, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF) -> every wb_wdata matches the reference model.
